// File: rtl/column_frame_scheduler.sv
// column_frame_scheduler
//
// Double-buffer manager and write arbiter for the per-column wall-height RAM
// read by the raycast VGA renderer. Two requesters (CPU request/grant port and
// the raycast engine valid/ready stream) share one registered RAM write port
// that always targets the hidden (back) bank. The displayed (front) bank is
// swapped only on a vsync falling edge after a commit, so the renderer never
// shows a half-written frame.
//
// Handshake: a CPU write transfers in any cycle where cpu_req && cpu_gnt; an
// engine beat transfers in any cycle where eng_valid && eng_ready. Both
// grant/ready are combinational from the current requests and state, at most
// one of them is high per cycle, and a requester that is not granted must hold
// its address/data (and eng_last) stable until it is.
//
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   cpu_req/addr/data     CPU write request; cpu_gnt accepts it
//   cpu_commit            pulse: back bank complete, request a swap
//   eng_valid/col/data    engine write beat; eng_ready accepts it
//   eng_last              engine beat is the frame's last column (commit)
//   vs                    VGA vsync, active low
//   ram_we/addr/wdata     registered RAM write port, addr = {back bank, col}
//   disp_bank             front bank used by the display read port
//   frame_pending         commit armed, waiting for vsync
//   frame_count           swaps performed (wrapping)
//   drop_count            out-of-range writes discarded (saturating)
//   fsm_state             debug view of the FSM (0 = FILL, 1 = PENDING)

module column_frame_scheduler #(
    parameter int NUM_COLS = 320,
    parameter int COL_W    = 9,
    parameter int DATA_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cpu_req,
    input  logic [COL_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_gnt,
    input  logic              cpu_commit,
    input  logic              eng_valid,
    input  logic [COL_W-1:0]  eng_col,
    input  logic [DATA_W-1:0] eng_data,
    input  logic              eng_last,
    output logic              eng_ready,
    input  logic              vs,
    output logic              ram_we,
    output logic [COL_W:0]    ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              disp_bank,
    output logic              frame_pending,
    output logic [15:0]       frame_count,
    output logic [7:0]        drop_count,
    output logic              fsm_state
);

    typedef enum logic {
        FILL    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Which requester won the most recent tie; the other one wins the next.
    typedef enum logic {
        RR_CPU = 1'b0,
        RR_ENG = 1'b1
    } rr_t;

    localparam logic [COL_W:0] NUM_COLS_W = (COL_W+1)'(NUM_COLS);

    state_t            state, state_next;
    rr_t               rr_last, rr_next;
    logic              vs_q;
    logic              vs_fall;
    logic              accept;
    logic              in_range;
    logic              swap;
    logic [COL_W-1:0]  acc_col;
    logic [DATA_W-1:0] acc_data;

    assign vs_fall       = vs_q & ~vs;
    assign frame_pending = (state == PENDING);
    assign fsm_state     = state;

    always_comb begin
        state_next = state;
        rr_next    = rr_last;
        cpu_gnt    = 1'b0;
        eng_ready  = 1'b0;
        swap       = 1'b0;

        case (state)
            FILL: begin
                if (cpu_req && eng_valid) begin
                    if (rr_last == RR_ENG) begin
                        cpu_gnt = 1'b1;
                        rr_next = RR_CPU;
                    end else begin
                        eng_ready = 1'b1;
                        rr_next   = RR_ENG;
                    end
                end else begin
                    cpu_gnt   = cpu_req;
                    eng_ready = eng_valid;
                end
                // A simultaneous cpu_commit and engine last beat is one commit.
                // A vsync edge seen here is ignored: the swap waits a frame.
                if (cpu_commit || (eng_ready && eng_last)) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (vs_fall) begin
                    swap       = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    assign accept   = cpu_gnt | eng_ready;
    assign acc_col  = cpu_gnt ? cpu_addr : eng_col;
    assign acc_data = cpu_gnt ? cpu_data : eng_data;
    assign in_range = ({1'b0, acc_col} < NUM_COLS_W);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= FILL;
            rr_last <= RR_ENG;
            vs_q <= 1'b1;
            disp_bank <= 1'b0;
            frame_count <= 16'd0;
            drop_count <= 8'd0;
            ram_we <= 1'b0;
            ram_addr <= '0;
            ram_wdata <= '0;
        end else begin
            state <= state_next;
            rr_last <= rr_next;
            vs_q <= vs;
            ram_we <= 1'b0;

            if (accept) begin
                if (in_range) begin
                    // Back bank is sampled before any swap, so a write
                    // accepted in the commit cycle lands in the old back bank.
                    ram_we <= 1'b1;
                    ram_addr <= {~disp_bank, acc_col};
                    ram_wdata <= acc_data;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end

            if (swap) begin
                disp_bank <= ~disp_bank;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_column_frame_scheduler.sv
module tb_column_frame_scheduler;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cpu_req, cpu_commit, eng_valid, eng_last, vs;
  logic [8:0]  cpu_addr, eng_col;
  logic [31:0] cpu_data, eng_data;
  logic        cpu_gnt, eng_ready, ram_we, disp_bank, frame_pending, fsm_state;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [15:0] frame_count;
  logic [7:0]  drop_count;

  int tests = 0;
  int fails = 0;

  // clock / reset block
  always #5 CLK = ~CLK;

  column_frame_scheduler #(.NUM_COLS(320), .COL_W(9), .DATA_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_gnt(cpu_gnt),
    .cpu_commit(cpu_commit),
    .eng_valid(eng_valid), .eng_col(eng_col), .eng_data(eng_data), .eng_last(eng_last),
    .eng_ready(eng_ready), .vs(vs),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .disp_bank(disp_bank), .frame_pending(frame_pending),
    .frame_count(frame_count), .drop_count(drop_count), .fsm_state(fsm_state)
  );

  // reference model: front bank, swap armed, who won the last tie,
  // counters, previous vs sample, and the queue of expected RAM writes
  logic        m_bank, m_pend, m_tie_eng, m_vsq;
  logic [15:0] m_fc;
  logic [7:0]  m_dc;
  logic [41:0] exp_q[$];
  logic        obs_cg, obs_er;

  task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bank = 1'b0; m_pend = 1'b0; m_tie_eng = 1'b1; m_vsq = 1'b1;
    m_fc = 16'd0; m_dc = 8'd0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_addr = 0; cpu_data = 0; cpu_commit = 0;
    eng_valid = 0; eng_col = 0; eng_data = 0; eng_last = 0; vs = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_wdata"}, ram_wdata, 0);
    check({tag, "_disp_bank"}, disp_bank, 0);
    check({tag, "_frame_pending"}, frame_pending, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_drop_count"}, drop_count, 0);
  endtask

  // called at a negedge; returns at the following negedge
  task automatic do_reset();
    idle_inputs();
    RESET = 1'b1;
    #2;
    check_reset_outputs("rst");
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  // driver + scoreboard for one clock cycle, called at a negedge
  task automatic cycle(input logic cr, input logic [8:0] ca, input logic [31:0] cd,
                       input logic cc, input logic ev, input logic [8:0] ec,
                       input logic [31:0] ed, input logic el, input logic vsi);
    logic exp_cg, exp_er;
    logic [8:0]  col;
    logic [31:0] d;
    logic [41:0] e;
    cpu_req = cr; cpu_addr = ca; cpu_data = cd; cpu_commit = cc;
    eng_valid = ev; eng_col = ec; eng_data = ed; eng_last = el; vs = vsi;
    #1;
    exp_cg = !m_pend && cr && (!ev || m_tie_eng);
    exp_er = !m_pend && ev && (!cr || !m_tie_eng);
    obs_cg = cpu_gnt;
    obs_er = eng_ready;
    check("cpu_gnt", cpu_gnt, exp_cg);
    check("eng_ready", eng_ready, exp_er);
    check("frame_pending", frame_pending, m_pend);
    check("disp_bank", disp_bank, m_bank);
    check("frame_count", frame_count, m_fc);
    check("drop_count", drop_count, m_dc);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ram_we", ram_we, 1);
      check("ram_addr_data", {ram_addr, ram_wdata}, e);
    end else begin
      check("ram_we", ram_we, 0);
    end
    // advance the model by one cycle
    if (m_pend) begin
      if (m_vsq && !vsi) begin
        m_bank = ~m_bank;
        m_fc = m_fc + 16'd1;
        m_pend = 1'b0;
      end
    end else begin
      if (exp_cg || exp_er) begin
        col = exp_cg ? ca : ec;
        d   = exp_cg ? cd : ed;
        if (col < 9'd320) exp_q.push_back({~m_bank, col, d});
        else if (m_dc != 8'hFF) m_dc = m_dc + 8'd1;
      end
      if (cr && ev) m_tie_eng = exp_er;
      if (cc || (exp_er && el)) m_pend = 1'b1;
    end
    m_vsq = vsi;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  logic [3:0] gnt_pat;

  initial begin
    idle_inputs();
    RESET = 1'b1;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // CPU write col 5 -> bank 1
    cycle(1, 9'd5, 32'h1234, 0, 0, 0, 0, 0, 1);
    check("tp1_we", ram_we, 1);
    check("tp1_addr", ram_addr, 10'h205);
    check("tp1_data", ram_wdata, 32'h1234);
    check("tp1_bank", disp_bank, 0);

    // tie for 4 cycles: CPU, ENG, CPU, ENG
    for (int i = 0; i < 4; i++) begin
      cycle(1, 9'(10 + i), 32'hC000 + i, 0, 1, 9'(20 + i), 32'hE000 + i, 0, 1);
      gnt_pat[3-i] = obs_cg;
    end
    check("tp2_pattern", gnt_pat, 4'b1010);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // out-of-range engine beats
    cycle(0, 0, 0, 0, 1, 9'd320, 32'hDEAD, 0, 1);
    check("tp3_ready", obs_er, 1);
    check("tp3_no_we", ram_we, 0);
    check("tp3_drop1", drop_count, 8'd1);
    for (int i = 0; i < 300; i++)
      cycle(0, 0, 0, 0, 1, 9'($urandom_range(320, 511)), $urandom, 0, 1);
    check("tp3_sat", drop_count, 8'hFF);

    // commit, long wait with requests stalled, then vsync edge
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 100; i++)
      cycle(1, 9'd7, 32'h7777, 0, 1, 9'd8, 32'h8888, 0, 1);
    check("tp4_pending", frame_pending, 1);
    cycle(1, 9'd7, 32'h7777, 0, 1, 9'd8, 32'h8888, 0, 0);
    check("tp4_bank", disp_bank, 1);
    check("tp4_fc", frame_count, 16'd1);
    cycle(1, 9'd7, 32'h7777, 0, 0, 0, 0, 0, 0);
    check("tp4_addr", ram_addr, 10'h007);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // last beat + commit in the same cycle as a vsync edge
    do_reset();
    cycle(0, 0, 0, 1, 1, 9'd319, 32'hABCD, 1, 0);
    check("tp5_addr", ram_addr, 10'h33F);
    check("tp5_noswap", disp_bank, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("tp5_swap", disp_bank, 1);
    check("tp5_fc", frame_count, 16'd1);

    // randomized traffic
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 1), 9'($urandom_range(0, 330)), $urandom,
            ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
            9'($urandom_range(0, 330)), $urandom,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) != 0));

    // reset while pending
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("tp6_pending", frame_pending, 1);
    #2;
    RESET = 1'b1;
    #1;
    check_reset_outputs("tp6");
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("tp6_noswap", disp_bank, 0);
    check("tp6_fc", frame_count, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/column_frame_scheduler.md
# column_frame_scheduler

Double-buffer manager and write arbiter for the per-column wall-height RAM feeding the raycast VGA renderer. Two requesters write column heights into the hidden (back) bank: the Nios CPU via a simple request/grant port and the hardware raycast engine via a valid/ready stream. The block owns a single RAM write port and swaps the displayed (front) bank only at the start of vertical sync, so that a half-written frame is never shown.

## Interface
- NUM_COLS, 320, number of valid columns per bank (screen width / 2)
- COL_W, 9, column index width
- DATA_W, 32, height word width (same fixed-point format the renderer shifts by 5)
- CLK  in  1  system clock, 50 MHz, shared with the VGA controller
- RESET  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU write request
- cpu_addr  in  COL_W  CPU target column
- cpu_data  in  DATA_W  CPU height word
- cpu_gnt  out  1  CPU write accepted this cycle (combinational)
- cpu_commit  in  1  single-cycle pulse: back bank complete, request swap
- eng_valid  in  1  engine write valid
- eng_col  in  COL_W  engine target column
- eng_data  in  DATA_W  engine height word
- eng_last  in  1  qualifies the engine beat as the frame's last column; acts as commit
- eng_ready  out  1  engine beat accepted this cycle (combinational)
- vs  in  1  VGA vsync, active low, from the VGA controller
- ram_we  out  1  RAM write strobe
- ram_addr  out  COL_W+1  {back bank, column}
- ram_wdata  out  DATA_W  RAM write data
- disp_bank  out  1  front bank; the display read port uses {disp_bank, DrawX>>1}
- frame_pending  out  1  commit armed, waiting for vsync
- frame_count  out  16  number of swaps performed, wraps at 0xFFFF→0
- drop_count  out  8  out-of-range writes discarded, saturates at 0xFF

## Operation
- States: FILL, PENDING.
- FILL: the arbiter accepts at most one write per cycle.
  - Only one requester active: it is granted.
  - Both active: round-robin; the requester not granted last wins. After reset the CPU wins the first tie.
  - The round-robin pointer updates only on a tie.
- An accepted beat with column < NUM_COLS writes {~disp_bank, column}.
- An accepted beat with column >= NUM_COLS is accepted but not written. drop_count increments.
- Commit event: cpu_commit in FILL, or an accepted engine beat with eng_last=1. A commit moves the FSM FILL→PENDING.
  - If an engine last beat and cpu_commit arrive together, this is one commit.
  - cpu_commit while PENDING is ignored.
- PENDING: cpu_gnt=0 and eng_ready=0. Requesters stall and must hold their data.
- vsync falling edge (vs_q=1, vs=0; vs_q registered) while PENDING:
  - disp_bank toggles.
  - frame_count increments.
  - FSM returns to FILL.
- A vsync falling edge while in FILL has no effect.
- Reset values:
  - FSM=FILL, disp_bank=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - frame_pending=0, frame_count=0, drop_count=0.
  - vs_q=1, RR pointer=ENG (so the CPU wins the first tie).
- Reset asserted mid-frame abandons any pending swap and partially written data. RAM contents are untouched.

## Timing
- Grant/ready are combinational from the current-cycle requests and state.
- A beat accepted at cycle N produces ram_we/ram_addr/ram_wdata at cycle N+1, registered, and ram_we lasts one cycle.
- Commit at cycle N gives frame_pending=1 and stalls from N+1.
- A write accepted in cycle N, the commit cycle, lands at N+1 in the old back bank, before any swap.
- Earliest swap:
  - A vsync edge detected at cycle M ≥ N+1 with the FSM in PENDING toggles disp_bank at M+1.
  - frame_pending falls at M+1.
  - Grants can resume at M+1.
- A vsync edge detected in the same cycle as the commit does not swap. The swap waits for the next frame.

## Test plan
- Reset, then CPU writes col 5 = 0x1234 → at N+1: ram_we=1, ram_addr=0x205 (bank 1), ram_wdata=0x1234. disp_bank=0.
- cpu_req and eng_valid held high for 4 cycles → grants go CPU, ENG, CPU, ENG. One ram_we per cycle, with matching data.
- Engine beat with col 320 → eng_ready=1, no ram_we, drop_count=1. After 300 such beats drop_count stays 0xFF.
- cpu_commit pulse, then vs falls 100 cycles later:
  - Grants are 0 and frame_pending=1 for the whole wait.
  - disp_bank=1 one cycle after the edge is detected, frame_count=1.
  - The next CPU write targets bank 0 (ram_addr=0x0xx).
- Engine last beat (col 319) and cpu_commit in the same cycle as a vs falling edge:
  - The col 319 write goes to bank 1, the old back bank.
  - No swap on that edge. The swap happens on the next vs falling edge and frame_count is 1.
- RESET asserted while PENDING → all outputs return to reset values immediately (asynchronously). A later vs edge causes no swap.
